// File: rtl/arp_note_sequencer.sv
// arp_note_sequencer
//   Drives the divider of the sine-step clock. In PLAY it steps through four
//   notes (ratios 1, 5/4, 3/2, 2 of base_div) at a fixed tempo in a selectable
//   pattern. In IDLE it passes base_div straight through.
//
// Ports
//   CLK100MHZ   system clock
//   RST         synchronous, active-high reset
//   arp_en      1 = PLAY, 0 = IDLE
//   mode        0 up, 1 down, 2 up-down, 3 hold
//   base_div    base divider value
//   div_out     divider value for the sine ClockDivider (DIV_W+1 bits)
//   note_idx    current note index
//   note_start  one-cycle pulse on the first cycle of each note
//   mute        gate output
//
// Optional feature macro: ARP_GATE_EN
//   defined   : mute is high for the last NOTE_TICKS/8 cycles of every PLAY note
//   undefined : mute is tied low and no gate compare is built
module arp_note_sequencer #(
   parameter int DIV_W      = 12,
   parameter int NOTE_TICKS = 50_000_000
) (
   input  logic             CLK100MHZ,
   input  logic             RST,
   input  logic             arp_en,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] base_div,
   output logic [DIV_W:0]   div_out,
   output logic [1:0]       note_idx,
   output logic             note_start,
   output logic             mute
);

   localparam int CW = $clog2(NOTE_TICKS);
   localparam logic [CW-1:0] LAST = CW'(NOTE_TICKS - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PLAY = 1'b1;

   localparam logic [1:0] M_UP   = 2'd0;
   localparam logic [1:0] M_DOWN = 2'd1;
   localparam logic [1:0] M_UPDN = 2'd2;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic          dir;       // 1 = ascending (up-down pattern only)
   logic          dir_eff;
   logic [1:0]    idx_nxt;
   logic [1:0]    div_sel;

   // Ratio arithmetic is done DIV_W+1 wide so note 3 (b<<1) never overflows.
   function automatic logic [DIV_W:0] ratio(input logic [1:0] sel,
                                            input logic [DIV_W-1:0] b_in);
      logic [DIV_W:0] b;
      b = {1'b0, b_in};
      case (sel)
         2'd0:    ratio = b;
         2'd1:    ratio = b + (b >> 2);
         2'd2:    ratio = b + (b >> 1);
         default: ratio = b << 1;
      endcase
   endfunction

   always_comb begin
      // Endpoints force the direction so up-down never repeats 0 or 3.
      dir_eff = dir;
      if (note_idx == 2'd3)      dir_eff = 1'b0;
      else if (note_idx == 2'd0) dir_eff = 1'b1;

      idx_nxt = note_idx;
      case (mode)
         M_UP:    idx_nxt = note_idx + 2'd1;
         M_DOWN:  idx_nxt = note_idx - 2'd1;
         M_UPDN:  idx_nxt = dir_eff ? note_idx + 2'd1 : note_idx - 2'd1;
         default: idx_nxt = note_idx;
      endcase

      // Abandoning a note (arp_en low) snaps div_out back to the base note
      // together with note_idx.
      div_sel = (state == S_PLAY && arp_en) ? note_idx : 2'd0;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state      <= S_IDLE;
         cnt        <= '0;
         note_idx   <= 2'd0;
         dir        <= 1'b1;
         note_start <= 1'b0;
         div_out    <= '0;
      end else begin
         note_start <= 1'b0;
         div_out    <= ratio(div_sel, base_div);
         case (state)
            S_IDLE: begin
               note_idx <= 2'd0;
               cnt      <= '0;
               dir      <= 1'b1;
               if (arp_en) begin
                  state      <= S_PLAY;
                  note_start <= 1'b1;
               end
            end
            S_PLAY: begin
               if (!arp_en) begin
                  // Leaving wins over a coincident note boundary.
                  state    <= S_IDLE;
                  note_idx <= 2'd0;
                  cnt      <= '0;
                  dir      <= 1'b1;
               end else if (cnt == LAST) begin
                  // mode is only consulted here, so changes land on a boundary.
                  cnt        <= '0;
                  note_idx   <= idx_nxt;
                  note_start <= 1'b1;
                  if (mode == M_UPDN) dir <= dir_eff;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ARP_GATE_EN
   localparam logic [CW-1:0] GATE_TH = CW'(NOTE_TICKS - NOTE_TICKS / 8);

   // Registered from the next counter value so mute lines up with cnt.
   always_ff @(posedge CLK100MHZ) begin
      if (RST)
         mute <= 1'b0;
      else
         mute <= (state == S_PLAY) && arp_en && (cnt != LAST) &&
                 ((cnt + CW'(1)) >= GATE_TH);
   end
`else
   assign mute = 1'b0;
`endif

endmodule

// File: tb/tb_arp_note_sequencer.sv
// Testbench for arp_note_sequencer (NOTE_TICKS=8, DIV_W=12).
// Inputs are driven just after the falling edge, outputs sampled on the
// falling edge after each rising edge.
module tb_arp_note_sequencer;

   localparam int DIV_W = 12;
   localparam int NT    = 8;
`ifdef ARP_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic             CLK100MHZ = 1'b0;
   logic             RST = 1'b1;
   logic             arp_en = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [DIV_W-1:0] base_div = 12'd800;
   logic [DIV_W:0]   div_out;
   logic [1:0]       note_idx;
   logic             note_start;
   logic             mute;

   arp_note_sequencer #(.DIV_W(DIV_W), .NOTE_TICKS(NT)) dut (
      .CLK100MHZ (CLK100MHZ),
      .RST       (RST),
      .arp_en    (arp_en),
      .mode      (mode),
      .base_div  (base_div),
      .div_out   (div_out),
      .note_idx  (note_idx),
      .note_start(note_start),
      .mute      (mute)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   typedef struct {
      logic        rst;
      logic        en;
      logic [1:0]  md;
      logic [11:0] b;
      logic [12:0] ediv;
      logic [1:0]  eidx;
      logic        est;
      logic        emute;
   } vec_t;

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic step();
      @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void addv(input logic rst, input logic en, input logic [1:0] md,
                                input logic [11:0] b, input logic [12:0] ediv,
                                input logic [1:0] eidx, input logic est, input logic em);
      vec_t v;
      v.rst = rst; v.en = en; v.md = md; v.b = b;
      v.ediv = ediv; v.eidx = eidx; v.est = est; v.emute = em;
      vq.push_back(v);
   endfunction

   initial begin
      int dv[4];
      int ud[14];
      dv = '{800, 1000, 1200, 1600};
      ud = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1};

      // ---- vector table: reset, idle pass-through, mode-up run ----
      addv(1, 0, 0, 800, 0,   0, 0, 0);
      addv(1, 0, 0, 800, 0,   0, 0, 0);
      addv(0, 0, 0, 800, 800, 0, 0, 0);
      addv(0, 0, 0, 800, 800, 0, 0, 0);
      // Notes 0..3 then the first two cycles of the wrap to note 0.
      // div_out trails note_idx by one cycle.
      for (int n = 0; n < 5; n++)
         for (int c = 0; c < NT; c++)
            if (n < 4 || c < 2)
               addv(0, 1, 0, 800,
                    13'((c == 0) ? ((n == 0) ? 800 : dv[n-1]) : dv[n%4]),
                    2'(n % 4), (c == 0), (c == NT-1));

      foreach (vq[i]) begin
         RST = vq[i].rst; arp_en = vq[i].en; mode = vq[i].md; base_div = vq[i].b;
         step();
         chk($sformatf("vec%0d div_out", i),    16'(div_out),    16'(vq[i].ediv));
         chk($sformatf("vec%0d note_idx", i),   16'(note_idx),   16'(vq[i].eidx));
         chk($sformatf("vec%0d note_start", i), 16'(note_start), 16'(vq[i].est));
         chk($sformatf("vec%0d mute", i),       16'(mute),       16'(vq[i].emute & GATE));
      end

      // ---- drop to IDLE ----
      arp_en = 1'b0;
      step();
      chk("idle note_idx", 16'(note_idx), 16'd0);
      chk("idle div_out",  16'(div_out),  16'd800);
      chk("idle mute",     16'(mute),     16'd0);

      // ---- up-down, 14 notes ----
      mode = 2'd2; arp_en = 1'b1;
      for (int n = 0; n < 14; n++) begin
         step();
         chk($sformatf("updn note%0d start", n), 16'(note_start), 16'd1);
         chk($sformatf("updn note%0d idx", n),   16'(note_idx),   16'(ud[n]));
         repeat (NT-1) step();
         chk($sformatf("updn note%0d held", n),  16'(note_idx),   16'(ud[n]));
      end
      arp_en = 1'b0;
      step();
      chk("updn exit idx", 16'(note_idx), 16'd0);

      // ---- mode change mid-note (up -> down at counter 3 of note 1) ----
      mode = 2'd0; arp_en = 1'b1;
      step();
      repeat (NT-1) step();
      step();
      chk("mchg note1 start", 16'(note_start), 16'd1);
      chk("mchg note1 idx",   16'(note_idx),   16'd1);
      repeat (3) step();
      mode = 2'd1;
      repeat (4) step();
      chk("mchg note1 completes idx",   16'(note_idx),   16'd1);
      chk("mchg note1 completes start", 16'(note_start), 16'd0);
      step();
      chk("mchg next idx",   16'(note_idx),   16'd0);
      chk("mchg next start", 16'(note_start), 16'd1);
      chk("mchg next div",   16'(div_out),    16'd1000);
      repeat (NT) step();
      chk("down wrap idx", 16'(note_idx), 16'd3);

      // ---- arp_en falls exactly on the note boundary ----
      mode = 2'd0;
      repeat (NT-1) step();
      chk("bnd pre idx",  16'(note_idx), 16'd3);
      chk("bnd pre mute", 16'(mute),     16'(GATE));
      arp_en = 1'b0; base_div = 12'd900;
      step();
      chk("bnd idle idx",   16'(note_idx),   16'd0);
      chk("bnd idle div",   16'(div_out),    16'd900);
      chk("bnd idle start", 16'(note_start), 16'd0);
      chk("bnd idle mute",  16'(mute),       16'd0);
      step();
      chk("bnd idle2 start", 16'(note_start), 16'd0);

      // ---- all-ones base on note 3, then mid-note base change ----
      base_div = 12'd4095; arp_en = 1'b1; mode = 2'd0;
      step();
      repeat (3*NT) step();
      chk("max idx3",      16'(note_idx), 16'd3);
      chk("max div note2", 16'(div_out),  16'd6142);
      step();
      chk("max div note3", 16'(div_out),  16'd8190);
      base_div = 12'd1000;
      step();
      chk("bchg div", 16'(div_out), 16'd2000);
      repeat (NT-3) step();
      chk("bchg timer start", 16'(note_start), 16'd0);
      step();
      chk("bchg timer boundary", 16'(note_start), 16'd1);
      chk("bchg wrap idx",       16'(note_idx),   16'd0);

      // ---- base 0 and hold mode ----
      base_div = 12'd0; mode = 2'd3;
      step();
      chk("zero div", 16'(div_out), 16'd0);
      repeat (NT-2) step();
      step();
      chk("hold start", 16'(note_start), 16'd1);
      chk("hold idx",   16'(note_idx),   16'd0);
      chk("hold div",   16'(div_out),    16'd0);

      // ---- reset mid-note ----
      base_div = 12'd800; mode = 2'd0;
      repeat (3) step();
      RST = 1'b1;
      step();
      chk("rst div",   16'(div_out),    16'd0);
      chk("rst start", 16'(note_start), 16'd0);
      chk("rst idx",   16'(note_idx),   16'd0);
      chk("rst mute",  16'(mute),       16'd0);
      RST = 1'b0;
      step();
      chk("rst reentry start", 16'(note_start), 16'd1);
      chk("rst reentry div",   16'(div_out),    16'd800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
